// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the LEGv8 core: latches the decode slot, inserts load-use
// bubbles, and owns the architectural NZVC flags plus a saturating bubble counter.
module id_ex_stage #(
    parameter int DW   = 64,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            dec_valid,
    input  logic [19:0]     dec_ctl,
    input  logic [4:0]      dec_rn,
    input  logic [4:0]      dec_rb,
    input  logic            dec_uses_rb,
    input  logic [4:0]      dec_rd,
    input  logic [DW-1:0]   dec_da,
    input  logic [DW-1:0]   dec_db,
    input  logic [DW-1:0]   dec_imm,
    input  logic [DW-1:0]   dec_pc,
    input  logic [3:0]      ex_alu_nzvc,
    output logic            stall,
    output logic            ex_valid,
    output logic [19:0]     ex_ctl,
    output logic [4:0]      ex_rn,
    output logic [4:0]      ex_rb,
    output logic [4:0]      ex_rd,
    output logic [DW-1:0]   ex_da,
    output logic [DW-1:0]   ex_db,
    output logic [DW-1:0]   ex_imm,
    output logic [DW-1:0]   ex_pc,
    output logic [3:0]      flags_nzvc,
    output logic [3:0]      flags_fwd,
    output logic [CNTW-1:0] bubble_cnt
);

    // Bit positions inside the 20-bit control word.
    localparam int CTL_FLAG   = 7;
    localparam int CTL_LOADOP = 1;

    logic hazard;
    logic ex_sets_flags;
    logic rn_match;
    logic rb_match;

    assign rn_match      = (ex_rd == dec_rn);
    assign rb_match      = dec_uses_rb && (ex_rd == dec_rb);
    assign hazard        = ex_valid && ex_ctl[CTL_LOADOP] && (ex_rd != 5'd31) &&
                           dec_valid && (rn_match || rb_match);
    assign stall         = hazard && !flush && !reset;
    assign ex_sets_flags = ex_valid && ex_ctl[CTL_FLAG];
    assign flags_fwd     = ex_sets_flags ? ex_alu_nzvc : flags_nzvc;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_ctl     <= '0;
            ex_rn      <= '0;
            ex_rb      <= '0;
            ex_rd      <= '0;
            ex_da      <= '0;
            ex_db      <= '0;
            ex_imm     <= '0;
            ex_pc      <= '0;
            flags_nzvc <= '0;
            bubble_cnt <= '0;
        end else begin
            // The flag writer is leaving EX regardless of what replaces it.
            if (ex_sets_flags) begin
                flags_nzvc <= ex_alu_nzvc;
            end
            if (flush) begin
                ex_valid <= 1'b0;
                ex_ctl   <= '0;
            end else if (hazard) begin
                ex_valid <= 1'b0;
                ex_ctl   <= '0;
                if (bubble_cnt != {CNTW{1'b1}}) begin
                    bubble_cnt <= bubble_cnt + 1'b1;
                end
            end else begin
                ex_valid <= dec_valid;
                ex_ctl   <= dec_valid ? dec_ctl : 20'd0;
                ex_rn    <= dec_rn;
                ex_rb    <= dec_rb;
                ex_rd    <= dec_rd;
                ex_da    <= dec_da;
                ex_db    <= dec_db;
                ex_imm   <= dec_imm;
                ex_pc    <= dec_pc;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus a randomized run against a
// cycle-level reference model of the stage's rules.
module tb_id_ex_stage;

    localparam int DW   = 64;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    localparam logic [19:0] CTL_LDUR = 20'h11B02;
    localparam logic [19:0] CTL_ADDS = 20'h40180;
    localparam logic [19:0] CTL_SUBS = 20'h60180;
    localparam logic [19:0] CTL_ADD  = 20'h40100;
    localparam logic [19:0] CTL_BLT  = 20'h00040;

    logic            clk = 1'b0;
    logic            reset, flush, dec_valid, dec_uses_rb;
    logic [19:0]     dec_ctl;
    logic [4:0]      dec_rn, dec_rb, dec_rd;
    logic [DW-1:0]   dec_da, dec_db, dec_imm, dec_pc;
    logic [3:0]      ex_alu_nzvc;
    logic            stall, ex_valid;
    logic [19:0]     ex_ctl;
    logic [4:0]      ex_rn, ex_rb, ex_rd;
    logic [DW-1:0]   ex_da, ex_db, ex_imm, ex_pc;
    logic [3:0]      flags_nzvc, flags_fwd;
    logic [CNTW-1:0] bubble_cnt;

    int tests_run = 0;
    int failed    = 0;

    // Reference model of the EX slot.
    logic          m_valid;
    logic [19:0]   m_ctl;
    logic [4:0]    m_rn, m_rb, m_rd;
    logic [DW-1:0] m_da, m_db, m_imm, m_pc;
    logic [3:0]    m_flags;
    int            m_cnt;

    id_ex_stage #(.DW(DW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .dec_valid(dec_valid), .dec_ctl(dec_ctl),
        .dec_rn(dec_rn), .dec_rb(dec_rb), .dec_uses_rb(dec_uses_rb), .dec_rd(dec_rd),
        .dec_da(dec_da), .dec_db(dec_db), .dec_imm(dec_imm), .dec_pc(dec_pc),
        .ex_alu_nzvc(ex_alu_nzvc), .stall(stall), .ex_valid(ex_valid), .ex_ctl(ex_ctl),
        .ex_rn(ex_rn), .ex_rb(ex_rb), .ex_rd(ex_rd), .ex_da(ex_da), .ex_db(ex_db),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .flags_nzvc(flags_nzvc), .flags_fwd(flags_fwd),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic model_hazard();
        return m_valid && m_ctl[1] && (m_rd != 5'd31) && dec_valid &&
               ((m_rd == dec_rn) || (dec_uses_rb && (m_rd == dec_rb)));
    endfunction

    // Advance the model with the inputs currently driven, then cross the clock edge.
    task automatic step();
        logic hz;
        hz = model_hazard();
        if (reset) begin
            m_valid = 0; m_ctl = 0; m_rn = 0; m_rb = 0; m_rd = 0;
            m_da = 0; m_db = 0; m_imm = 0; m_pc = 0; m_flags = 0; m_cnt = 0;
        end else begin
            if (m_valid && m_ctl[7]) m_flags = ex_alu_nzvc;
            if (flush || hz) begin
                m_valid = 0;
                m_ctl   = 0;
                if (!flush && m_cnt < CMAX) m_cnt++;
            end else begin
                m_valid = dec_valid;
                m_ctl   = dec_valid ? dec_ctl : 20'd0;
                m_rn = dec_rn; m_rb = dec_rb; m_rd = dec_rd;
                m_da = dec_da; m_db = dec_db; m_imm = dec_imm; m_pc = dec_pc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_dec(input logic v, input logic [19:0] c, input logic [4:0] rn,
                             input logic [4:0] rb, input logic urb, input logic [4:0] rd);
        dec_valid = v; dec_ctl = c; dec_rn = rn; dec_rb = rb; dec_uses_rb = urb; dec_rd = rd;
        dec_da  = {$urandom, $urandom};
        dec_db  = {$urandom, $urandom};
        dec_imm = {$urandom, $urandom};
        dec_pc  = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        reset = 1; flush = 0; ex_alu_nzvc = 4'h0;
        drive_dec(0, 20'd0, 5'd0, 5'd0, 0, 5'd0);
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; flush = 0; ex_alu_nzvc = 4'($urandom);
        for (int i = 0; i < 2; i++) begin
            drive_dec(1, 20'($urandom), 5'($urandom), 5'($urandom), 1, 5'($urandom));
            #1;
            tests_run++;
            if (stall !== 1'b0) begin
                failed++; $display("FAIL reset_stall: got %b want 0", stall);
            end
            step();
        end
        tests_run++;
        if ({ex_valid, ex_ctl, ex_rn, ex_rb, ex_rd, ex_da, ex_db, ex_imm, ex_pc} !== '0) begin
            failed++; $display("FAIL reset_ex: valid=%b ctl=%h da=%h not all zero", ex_valid, ex_ctl, ex_da);
        end
        tests_run++;
        if (flags_nzvc !== 4'h0 || bubble_cnt !== '0) begin
            failed++; $display("FAIL reset_flags_cnt: flags=%h cnt=%0d want 0/0", flags_nzvc, bubble_cnt);
        end
        reset = 0;
    endtask

    task automatic test_load_use();
        do_reset();
        drive_dec(1, CTL_LDUR, 5'd1, 5'd0, 0, 5'd2);
        step();
        drive_dec(1, CTL_ADDS, 5'd2, 5'd3, 1, 5'd4);
        #1;
        tests_run++;
        if (stall !== 1'b1) begin failed++; $display("FAIL lu_stall: got %b want 1", stall); end
        step();
        tests_run++;
        if (ex_valid !== 1'b0 || ex_ctl !== 20'd0) begin
            failed++; $display("FAIL lu_bubble: valid=%b ctl=%h want 0/0", ex_valid, ex_ctl);
        end
        tests_run++;
        if (bubble_cnt !== 4'd1) begin failed++; $display("FAIL lu_cnt: got %0d want 1", bubble_cnt); end
        tests_run++;
        if (stall !== 1'b0) begin failed++; $display("FAIL lu_stall_drop: got %b want 0", stall); end
        step();
        tests_run++;
        if (ex_valid !== 1'b1 || ex_ctl !== CTL_ADDS || ex_rn !== 5'd2 || ex_rd !== 5'd4) begin
            failed++; $display("FAIL lu_enter: valid=%b ctl=%h rn=%0d rd=%0d want 1/%h/2/4",
                               ex_valid, ex_ctl, ex_rn, ex_rd, CTL_ADDS);
        end
    endtask

    task automatic test_x31();
        do_reset();
        drive_dec(1, CTL_LDUR, 5'd1, 5'd0, 0, 5'd31);
        step();
        drive_dec(1, CTL_ADD, 5'd31, 5'd31, 1, 5'd5);
        #1;
        tests_run++;
        if (stall !== 1'b0) begin failed++; $display("FAIL x31_stall: got %b want 0", stall); end
        step();
        tests_run++;
        if (ex_valid !== 1'b1 || bubble_cnt !== 4'd0) begin
            failed++; $display("FAIL x31_no_bubble: valid=%b cnt=%0d want 1/0", ex_valid, bubble_cnt);
        end
    endtask

    task automatic test_flush_hazard();
        do_reset();
        drive_dec(1, CTL_LDUR, 5'd1, 5'd0, 0, 5'd5);
        step();
        drive_dec(1, CTL_ADD, 5'd5, 5'd0, 0, 5'd6);
        flush = 1;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin failed++; $display("FAIL fh_stall: got %b want 0", stall); end
        step();
        flush = 0;
        tests_run++;
        if (ex_valid !== 1'b0 || ex_ctl !== 20'd0 || bubble_cnt !== 4'd0) begin
            failed++; $display("FAIL fh_state: valid=%b ctl=%h cnt=%0d want 0/0/0", ex_valid, ex_ctl, bubble_cnt);
        end
    endtask

    task automatic test_flags();
        do_reset();
        drive_dec(1, CTL_SUBS, 5'd1, 5'd2, 1, 5'd3);
        step();
        drive_dec(1, CTL_BLT, 5'd0, 5'd0, 0, 5'd0);
        ex_alu_nzvc = 4'b1000;
        #1;
        tests_run++;
        if (flags_fwd !== 4'b1000) begin failed++; $display("FAIL flags_fwd: got %b want 1000", flags_fwd); end
        tests_run++;
        if (flags_nzvc !== 4'b0000) begin failed++; $display("FAIL flags_pre: got %b want 0000", flags_nzvc); end
        step();
        tests_run++;
        if (flags_nzvc !== 4'b1000) begin failed++; $display("FAIL flags_write: got %b want 1000", flags_nzvc); end
        drive_dec(1, CTL_ADD, 5'd1, 5'd2, 1, 5'd3);
        ex_alu_nzvc = 4'b0110;
        step();
        ex_alu_nzvc = 4'b0111;
        #1;
        tests_run++;
        if (flags_fwd !== 4'b1000) begin failed++; $display("FAIL flags_fwd_noflag: got %b want 1000", flags_fwd); end
        step();
        tests_run++;
        if (flags_nzvc !== 4'b1000) begin failed++; $display("FAIL flags_hold: got %b want 1000", flags_nzvc); end
        ex_alu_nzvc = 4'h0;
    endtask

    task automatic test_saturate();
        int exp_cnt;
        do_reset();
        exp_cnt = 0;
        for (int i = 0; i < CMAX + 3; i++) begin
            drive_dec(1, CTL_LDUR, 5'd1, 5'd0, 0, 5'd3);
            step();
            drive_dec(1, CTL_ADD, 5'd3, 5'd0, 0, 5'd4);
            #1;
            tests_run++;
            if (stall !== 1'b1) begin failed++; $display("FAIL sat_stall[%0d]: got %b want 1", i, stall); end
            step();
            if (exp_cnt < CMAX) exp_cnt++;
            tests_run++;
            if (bubble_cnt !== CNTW'(exp_cnt)) begin
                failed++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bubble_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] rn, rb;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? m_rd : 5'($urandom);
            drive_dec(1'($urandom_range(0, 4) != 0),
                      20'($urandom) | (($urandom_range(0, 1) != 0) ? 20'h2 : 20'h0),
                      rn, rb, 1'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) dec_rd = 5'd31;
            flush       = ($urandom_range(0, 9) == 0);
            reset       = ($urandom_range(0, 39) == 0);
            ex_alu_nzvc = 4'($urandom);
            #1;
            tests_run++;
            if (stall !== (model_hazard() && !flush && !reset)) begin
                failed++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall, model_hazard() && !flush && !reset);
            end
            tests_run++;
            if (flags_fwd !== ((m_valid && m_ctl[7]) ? ex_alu_nzvc : m_flags)) begin
                failed++; $display("FAIL rnd_fwd[%0d]: got %b", i, flags_fwd);
            end
            step();
            tests_run++;
            if (ex_valid !== m_valid || ex_ctl !== m_ctl) begin
                failed++; $display("FAIL rnd_ctl[%0d]: got %b/%h want %b/%h", i, ex_valid, ex_ctl, m_valid, m_ctl);
            end
            tests_run++;
            if (flags_nzvc !== m_flags || bubble_cnt !== CNTW'(m_cnt)) begin
                failed++; $display("FAIL rnd_flags_cnt[%0d]: got %b/%0d want %b/%0d", i, flags_nzvc, bubble_cnt, m_flags, m_cnt);
            end
            if (m_valid) begin
                tests_run++;
                if ({ex_rn, ex_rb, ex_rd, ex_da, ex_db, ex_imm, ex_pc} !==
                    {m_rn, m_rb, m_rd, m_da, m_db, m_imm, m_pc}) begin
                    failed++; $display("FAIL rnd_data[%0d]: got rd=%0d da=%h pc=%h want rd=%0d da=%h pc=%h",
                                       i, ex_rd, ex_da, ex_pc, m_rd, m_da, m_pc);
                end
            end
        end
        reset = 0; flush = 0;
    endtask

    initial begin
        reset = 1; flush = 0; ex_alu_nzvc = 0;
        drive_dec(0, 20'd0, 5'd0, 5'd0, 0, 5'd0);
        #1;
        test_reset();
        test_load_use();
        test_x31();
        test_flush_hazard();
        test_flags();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
